// File: rtl/inst_fetch.sv
// Instruction fetch unit: PC sequencing, redirect handling and an instruction/PC buffer toward decode.
// Define IFETCH_DUAL_ISSUE_EN to fetch two words per accepted bus request; the default build fetches one.
module inst_fetch #(
    parameter logic [31:0] RESET_PC   = 32'hBFC0_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] bus_address,
    output logic        bus_read,
    input  logic        bus_stall,
    input  logic [31:0] bus_data_rd,
    input  logic [31:0] bus_data_rd_2,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
`ifdef IFETCH_DUAL_ISSUE_EN
    localparam int WPF = 2;
`else
    localparam int WPF = 1;
`endif

    typedef enum logic {RUN, REDIR} state_t;

    state_t             r_state;
    logic [31:0]        r_pc;
    logic [CNT_W-1:0]   r_count;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [31:0]        r_mem_inst [FIFO_DEPTH];
    logic [31:0]        r_mem_pc   [FIFO_DEPTH];

    logic [CNT_W-1:0]   w_free;
    logic               w_push;
    logic               w_pop;

    // Free space is judged before this cycle's pop so a fetch never relies on a concurrent drain.
    assign w_free      = CNT_W'(FIFO_DEPTH) - r_count;
    assign bus_read    = !rst && (r_state == RUN) && (w_free >= CNT_W'(WPF));
    assign bus_address = r_pc;

    assign w_push = bus_read && !bus_stall && !redirect_valid;
    assign w_pop  = (r_count != '0) && out_ready && !redirect_valid;

    assign out_valid = (r_count != '0);
    assign out_inst  = out_valid ? r_mem_inst[r_rd_ptr] : 32'h0;
    assign out_pc    = out_valid ? r_mem_pc[r_rd_ptr]   : 32'h0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= RUN;
            r_pc     <= {RESET_PC[31:2], 2'b00};
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (redirect_valid) begin
            r_state  <= REDIR;
            r_pc     <= {redirect_pc[31:2], 2'b00};
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_state <= RUN;
            if (w_push) begin
                r_pc     <= r_pc + 32'(4 * WPF);
                r_wr_ptr <= r_wr_ptr + PTR_W'(WPF);
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + (w_push ? CNT_W'(WPF) : CNT_W'(0))
                               - (w_pop ? CNT_W'(1) : CNT_W'(0));
        end
    end

    // Buffer storage carries no reset; validity is tracked solely by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_inst[r_wr_ptr] <= bus_data_rd;
            r_mem_pc[r_wr_ptr]   <= r_pc;
`ifdef IFETCH_DUAL_ISSUE_EN
            r_mem_inst[r_wr_ptr + PTR_W'(1)] <= bus_data_rd_2;
            r_mem_pc[r_wr_ptr + PTR_W'(1)]   <= r_pc + 32'd4;
`endif
        end
    end

`ifndef IFETCH_DUAL_ISSUE_EN
    logic w_unused_rd2;
    assign w_unused_rd2 = ^bus_data_rd_2;
`endif

endmodule
